// File: rtl/bin_to_bcd_seq.sv
// Sequential 32-bit binary to BCD converter (shift-add-3), fixed 33-edge latency.
// Define BCD_SATURATE_EN to clamp bcd_out to 16'h9999 when the value exceeds 9999.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t      state;
    logic [31:0] bin;
    logic [39:0] acc;
    logic [5:0]  cnt;
    logic [39:0] adj;
    logic        ovf;
    logic [15:0] bcd_next;

    // Pre-shift correction: any digit >= 5 would overflow past 9 when doubled.
    always_comb begin
        adj = acc;
        for (int i = 0; i < 10; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign ovf = |acc[39:16];

`ifdef BCD_SATURATE_EN
    assign bcd_next = ovf ? 16'h9999 : acc[15:0];
`else
    assign bcd_next = acc[15:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bin      <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin   <= value_in;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, bin} <= {adj[38:0], bin, 1'b0};
                    cnt        <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bcd_out  <= bcd_next;
                    overflow <= ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq; expectations follow BCD_SATURATE_EN.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset_n;
    logic [31:0] value_in;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int tests;
    int fails;

    bin_to_bcd_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .value_in (value_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start at edge 0, optionally poke value_in/start at edge poke, watch 40 edges.
    task automatic conv(input string tag, input logic [31:0] v,
                        input logic [15:0] exp_bcd, input logic exp_ovf,
                        input int poke, input logic [31:0] poke_val);
        int first;
        int pulses;
        first  = 0;
        pulses = 0;
        @(negedge clk);
        value_in = v;
        start    = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy0"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (e == poke) begin
                value_in = poke_val;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first == 0) first = e;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_lat"}, first, 33);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        check({tag, "_ovf"}, overflow, exp_ovf);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [15:0] sat12345;
    logic [15:0] satmax;
    int d1;
    int d2;
    int seen;

    initial begin
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        value_in = '0;
`ifdef BCD_SATURATE_EN
        sat12345 = 16'h9999;
        satmax   = 16'h9999;
`else
        sat12345 = 16'h2345;
        satmax   = 16'h7295;
`endif
        do_reset();

        conv("zero", 32'd0, 16'h0000, 1'b0, 0, 0);
        conv("v1234", 32'd1234, 16'h1234, 1'b0, 0, 0);
        conv("v9999", 32'd9999, 16'h9999, 1'b0, 0, 0);
        conv("v12345", 32'd12345, sat12345, 1'b1, 0, 0);
        conv("vmax", 32'hFFFF_FFFF, satmax, 1'b1, 0, 0);
        conv("v10000", 32'd10000, sat12345 == 16'h9999 ? 16'h9999 : 16'h0000,
             1'b1, 0, 0);
        conv("ign", 32'd42, 16'h0042, 1'b0, 10, 32'd777);

        // start held high: back-to-back conversions every 34 cycles
        d1 = 0;
        d2 = 0;
        @(negedge clk);
        value_in = 32'd8765;
        start    = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 == 0) d1 = e;
                else if (d2 == 0) d2 = e;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("hold_d1", d1, 33);
        check("hold_d2", d2, 67);
        check("hold_bcd", bcd_out, 16'h8765);

        // reset mid-conversion leaves no result and no done
        do_reset();
        seen = 0;
        @(negedge clk);
        value_in = 32'd5678;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e < 15; e++) @(negedge clk);
        reset_n = 1'b0;
        #2;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_nodone", seen, 0);
        check("abort_bcd", bcd_out, 16'h0000);
        conv("after", 32'd5678, 16'h5678, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
